// File: rtl/hatch_obi_sram_resp.sv
// OBI responder backed by a word-organised SRAM: byte-enable writes, fixed
// response latency, bounded outstanding transactions, bus error on bad accesses.
module hatch_obi_sram_resp #(
   parameter int          DEPTH_WORDS     = 1024,
   parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
   parameter int          RESP_LATENCY    = 1,
   parameter int          MAX_OUTSTANDING = 2
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_i,
   output logic        gnt_o,
   input  logic [31:0] addr_i,
   input  logic        we_i,
   input  logic [3:0]  be_i,
   input  logic [31:0] wdata_i,
   input  logic [5:0]  atop_i,
   output logic        rvalid_o,
   output logic [31:0] rdata_o,
   output logic        err_o,
   output logic        exokay_o
);

   localparam int          IDX_W   = $clog2(DEPTH_WORDS);
   localparam logic [32:0] SPAN    = 33'(4 * DEPTH_WORDS);
   localparam logic [2:0]  MAX_OUT = 3'(MAX_OUTSTANDING);

   logic [31:0]      mem [DEPTH_WORDS];
   logic [2:0]       outstanding_q;
   logic [32:0]      offset;
   logic             in_range;
   logic             acc_err;
   logic             accept;
   logic             retire;
   logic [IDX_W-1:0] word_idx;

   logic             vld_p   [RESP_LATENCY];
   logic             err_p   [RESP_LATENCY];
   logic [31:0]      rdata_p [RESP_LATENCY];

   // The extra top bit of offset catches addresses below BASE_ADDR (borrow).
   assign offset   = {1'b0, addr_i} - {1'b0, BASE_ADDR};
   assign in_range = !offset[32] && (offset < SPAN);
   assign acc_err  = !in_range || (atop_i != 6'd0);
   assign word_idx = offset[IDX_W+1:2];

   assign gnt_o    = rst_ni && (outstanding_q < MAX_OUT);
   assign accept   = req_i && gnt_o;
   assign retire   = vld_p[RESP_LATENCY-1];

   always_ff @(posedge clk_i) begin
      if (accept && !acc_err && we_i) begin
         for (int i = 0; i < 4; i++) begin
            if (be_i[i]) mem[word_idx][8*i +: 8] <= wdata_i[8*i +: 8];
         end
      end
   end

   // Stage 0: capture response at acceptance; later stages only shift.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         outstanding_q <= 3'd0;
         for (int k = 0; k < RESP_LATENCY; k++) vld_p[k] <= 1'b0;
      end else begin
         vld_p[0] <= accept;
         for (int k = 1; k < RESP_LATENCY; k++) vld_p[k] <= vld_p[k-1];
         case ({accept, retire})
            2'b10:   outstanding_q <= outstanding_q + 3'd1;
            2'b01:   outstanding_q <= outstanding_q - 3'd1;
            default: outstanding_q <= outstanding_q;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      err_p[0]   <= acc_err;
      rdata_p[0] <= (acc_err || we_i) ? 32'd0 : mem[word_idx];
      for (int k = 1; k < RESP_LATENCY; k++) begin
         err_p[k]   <= err_p[k-1];
         rdata_p[k] <= rdata_p[k-1];
      end
   end

   // Output stage: payload is forced to zero outside a valid response.
   assign rvalid_o = vld_p[RESP_LATENCY-1];
   assign err_o    = rvalid_o && err_p[RESP_LATENCY-1];
   assign rdata_o  = rvalid_o ? rdata_p[RESP_LATENCY-1] : 32'd0;
   assign exokay_o = 1'b0;

endmodule

// File: tb/tb_hatch_obi_sram_resp.sv
// Bench for hatch_obi_sram_resp: two instances (latency 1 and 4) checked every
// cycle against a transaction-level memory/response model.
module tb_hatch_obi_sram_resp;

   localparam logic [31:0] BASE  = 32'h0000_1000;
   localparam int          DEPTH = 64;
   localparam int          MAXO  = 2;
   localparam int          LAT [2] = '{1, 4};

   typedef struct {
      int          due;
      logic        err;
      logic [31:0] rdata;
   } resp_t;

   logic        clk = 1'b0;
   logic        rst_n [2];
   logic        req   [2];
   logic        gnt   [2];
   logic [31:0] addr  [2];
   logic        we    [2];
   logic [3:0]  be    [2];
   logic [31:0] wdata [2];
   logic [5:0]  atop  [2];
   logic        rvalid[2];
   logic [31:0] rdata [2];
   logic        err   [2];
   logic        exokay[2];

   logic [31:0] mem_m [2][DEPTH];
   resp_t       q0[$];
   resp_t       q1[$];
   int          cyc;
   int          errors = 0;
   int          checks = 0;
   logic [35:0] obs_v, exp_v;
   logic        last_acc;

   always #5 clk = ~clk;

   hatch_obi_sram_resp #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .RESP_LATENCY(1),
                         .MAX_OUTSTANDING(MAXO)) dut0 (
      .clk_i(clk), .rst_ni(rst_n[0]), .req_i(req[0]), .gnt_o(gnt[0]), .addr_i(addr[0]),
      .we_i(we[0]), .be_i(be[0]), .wdata_i(wdata[0]), .atop_i(atop[0]),
      .rvalid_o(rvalid[0]), .rdata_o(rdata[0]), .err_o(err[0]), .exokay_o(exokay[0]));

   hatch_obi_sram_resp #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .RESP_LATENCY(4),
                         .MAX_OUTSTANDING(MAXO)) dut1 (
      .clk_i(clk), .rst_ni(rst_n[1]), .req_i(req[1]), .gnt_o(gnt[1]), .addr_i(addr[1]),
      .we_i(we[1]), .be_i(be[1]), .wdata_i(wdata[1]), .atop_i(atop[1]),
      .rvalid_o(rvalid[1]), .rdata_o(rdata[1]), .err_o(err[1]), .exokay_o(exokay[1]));

   // One bus cycle on unit u: drive inputs, sample outputs, advance the model.
   // obs_v/exp_v = {gnt, rvalid, err, exokay, rdata}.
   task automatic step(input int u, input logic rst, input logic rq, input logic [31:0] a,
                       input logic w, input logic [3:0] b, input logic [31:0] wd,
                       input logic [5:0] at);
      resp_t       q[$];
      logic        eg, e;
      logic [31:0] rd;
      longint      la;
      int          idx;
      if (u == 0) q = q0; else q = q1;
      rst_n[u] = rst; req[u] = rq; addr[u] = a; we[u] = w;
      be[u] = b; wdata[u] = wd; atop[u] = at;
      #1;
      obs_v = {gnt[u], rvalid[u], err[u], exokay[u], rdata[u]};
      eg    = rst && (q.size() < MAXO);
      exp_v = {eg, 35'd0};
      if (q.size() > 0 && q[0].due == cyc) begin
         exp_v = {eg, 1'b1, q[0].err, 1'b0, q[0].rdata};
         void'(q.pop_front());
      end
      last_acc = rq && eg;
      if (!rst) begin
         q.delete();
      end else if (last_acc) begin
         la  = longint'(a);
         e   = (la < longint'(BASE)) || (la >= longint'(BASE) + 4 * DEPTH) || (at != 6'd0);
         idx = int'((la - longint'(BASE)) / 4);
         rd  = 32'd0;
         if (!e) begin
            if (w) begin
               for (int i = 0; i < 4; i++)
                  if (b[i]) mem_m[u][idx][8*i +: 8] = wd[8*i +: 8];
            end else begin
               rd = mem_m[u][idx];
            end
         end
         q.push_back('{due: cyc + LAT[u], err: e, rdata: rd});
      end
      if (u == 0) q0 = q; else q1 = q;
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic test_reset();
      for (int u = 0; u < 2; u++) begin
         repeat (2) begin
            step(u, 1'b0, 1'b1, BASE, 1'b0, 4'hF, 32'd0, 6'd0);
            checks++;
            if (obs_v !== 36'd0) begin errors++; $display("FAIL reset u=%0d got=%h want=%h", u, obs_v, 36'd0); end
         end
         step(u, 1'b1, 1'b0, BASE, 1'b0, 4'h0, 32'd0, 6'd0);
         checks++;
         if (obs_v !== exp_v) begin errors++; $display("FAIL reset_release u=%0d got=%h want=%h", u, obs_v, exp_v); end
      end
   endtask

   task automatic test_fill();
      for (int u = 0; u < 2; u++) begin
         for (int w = 0; w < DEPTH; w++) begin
            step(u, 1'b1, 1'b1, BASE + 32'(4 * w), 1'b1, 4'hF, {16'($urandom), 16'(w)}, 6'd0);
            if (!last_acc) w--;
            checks++;
            if (obs_v !== exp_v) begin errors++; $display("FAIL fill u=%0d cyc=%0d got=%h want=%h", u, cyc, obs_v, exp_v); end
         end
         repeat (6) begin
            step(u, 1'b1, 1'b0, BASE, 1'b0, 4'h0, 32'd0, 6'd0);
            checks++;
            if (obs_v !== exp_v) begin errors++; $display("FAIL fill_drain u=%0d got=%h want=%h", u, obs_v, exp_v); end
         end
      end
   endtask

   task automatic test_basic();
      step(0, 1'b1, 1'b1, BASE + 32'h10, 1'b1, 4'hF, 32'hDEAD_BEEF, 6'd0);
      checks++;
      if (obs_v !== exp_v) begin errors++; $display("FAIL basic_wr got=%h want=%h", obs_v, exp_v); end
      step(0, 1'b1, 1'b1, BASE + 32'h10, 1'b0, 4'h0, 32'd0, 6'd0);
      checks++;
      if (obs_v[34:0] !== {3'b100, 32'd0}) begin errors++; $display("FAIL basic_wr_resp got=%h want=%h", obs_v[34:0], {3'b100, 32'd0}); end
      step(0, 1'b1, 1'b0, BASE, 1'b0, 4'h0, 32'd0, 6'd0);
      checks++;
      if (obs_v[34:0] !== {3'b100, 32'hDEAD_BEEF}) begin errors++; $display("FAIL basic_rd got=%h want=%h", obs_v[34:0], {3'b100, 32'hDEAD_BEEF}); end
      step(0, 1'b1, 1'b0, BASE, 1'b0, 4'h0, 32'd0, 6'd0);
      checks++;
      if (obs_v !== exp_v) begin errors++; $display("FAIL basic_idle got=%h want=%h", obs_v, exp_v); end
   endtask

   task automatic test_byte_enable();
      logic [31:0] a [5] = '{BASE + 32'h20, BASE + 32'h20, BASE + 32'h22, BASE + 32'h20, BASE + 32'h21};
      logic        w [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      logic [3:0]  b [5] = '{4'hF, 4'b0101, 4'h0, 4'h0, 4'h3};
      logic [31:0] d [5] = '{32'h1122_3344, 32'hAABB_CCDD, 32'd0, 32'hFFFF_FFFF, 32'd0};
      for (int i = 0; i < 7; i++) begin
         if (i < 5) step(0, 1'b1, 1'b1, a[i], w[i], b[i], d[i], 6'd0);
         else       step(0, 1'b1, 1'b0, BASE, 1'b0, 4'h0, 32'd0, 6'd0);
         checks++;
         if (obs_v !== exp_v) begin errors++; $display("FAIL byte_en i=%0d got=%h want=%h", i, obs_v, exp_v); end
         if (i == 3 || i == 5) begin
            checks++;
            if (obs_v[34:0] !== {3'b100, 32'h11BB_33DD}) begin errors++; $display("FAIL byte_en_val i=%0d got=%h want=%h", i, obs_v[34:0], {3'b100, 32'h11BB_33DD}); end
         end
      end
   endtask

   task automatic test_errors();
      logic [31:0] a  [6] = '{BASE + 32'h100, BASE + 32'h20, BASE - 32'h4, 32'hFFFF_FFFC, BASE + 32'h20, BASE + 32'h20};
      logic        w  [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      logic [5:0]  at [6] = '{6'h0, 6'h2, 6'h0, 6'h0, 6'h1, 6'h0};
      for (int i = 0; i < 8; i++) begin
         if (i < 6) step(0, 1'b1, 1'b1, a[i], w[i], 4'hF, 32'h5555_AAAA, at[i]);
         else       step(0, 1'b1, 1'b0, BASE, 1'b0, 4'h0, 32'd0, 6'd0);
         checks++;
         if (obs_v !== exp_v) begin errors++; $display("FAIL errors i=%0d got=%h want=%h", i, obs_v, exp_v); end
         if (i >= 1 && i <= 5) begin
            checks++;
            if (obs_v[34:0] !== {3'b110, 32'd0}) begin errors++; $display("FAIL err_resp i=%0d got=%h want=%h", i, obs_v[34:0], {3'b110, 32'd0}); end
         end
      end
      checks++;
      if (mem_m[0][8] !== 32'h11BB_33DD) begin errors++; $display("FAIL err_nowrite got=%h want=%h", mem_m[0][8], 32'h11BB_33DD); end
   endtask

   task automatic test_throttle();
      int k = 0, acc = 0, seen = 0;
      repeat (8) begin
         step(1, 1'b1, 1'b1, BASE + 32'(4 * k), 1'b0, 4'hF, 32'd0, 6'd0);
         if (last_acc) begin k++; acc++; end
         if (obs_v[34]) seen++;
         checks++;
         if (obs_v !== exp_v) begin errors++; $display("FAIL throttle cyc=%0d got=%h want=%h", cyc, obs_v, exp_v); end
      end
      repeat (8) begin
         step(1, 1'b1, 1'b0, BASE, 1'b0, 4'h0, 32'd0, 6'd0);
         if (obs_v[34]) seen++;
         checks++;
         if (obs_v !== exp_v) begin errors++; $display("FAIL throttle_drain cyc=%0d got=%h want=%h", cyc, obs_v, exp_v); end
      end
      checks++;
      if (seen !== acc || acc > 4) begin errors++; $display("FAIL throttle_count got=%0d want=%0d", seen, acc); end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 10; i++) begin
         step(1, (i != 2), (i < 2), BASE + 32'(4 * i), 1'b0, 4'hF, 32'd0, 6'd0);
         checks++;
         if (obs_v !== exp_v) begin errors++; $display("FAIL rst_mid i=%0d got=%h want=%h", i, obs_v, exp_v); end
         if (i == 2 || i == 3) begin
            checks++;
            if (obs_v[35] !== (i == 3)) begin errors++; $display("FAIL rst_mid_gnt i=%0d got=%b want=%b", i, obs_v[35], (i == 3)); end
         end
      end
   endtask

   task automatic test_raw();
      logic [31:0] a;
      for (int i = 0; i < 10; i++) begin
         a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
         step(0, 1'b1, 1'b1, a, 1'b1, 4'hF, $urandom, 6'd0);
         checks++;
         if (obs_v !== exp_v) begin errors++; $display("FAIL raw_wr i=%0d got=%h want=%h", i, obs_v, exp_v); end
         step(0, 1'b1, 1'b1, a, 1'b0, 4'h0, 32'd0, 6'd0);
         checks++;
         if (obs_v !== exp_v) begin errors++; $display("FAIL raw_rd i=%0d got=%h want=%h", i, obs_v, exp_v); end
      end
      repeat (2) begin
         step(0, 1'b1, 1'b0, BASE, 1'b0, 4'h0, 32'd0, 6'd0);
         checks++;
         if (obs_v !== exp_v) begin errors++; $display("FAIL raw_drain got=%h want=%h", obs_v, exp_v); end
      end
   endtask

   task automatic test_random();
      logic [31:0] a;
      logic [5:0]  at;
      for (int u = 0; u < 2; u++) begin
         for (int i = 0; i < 160; i++) begin
            case ($urandom_range(0, 9))
               0:       a = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 15));
               1:       a = BASE - 32'(4 * $urandom_range(1, 4));
               default: a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(0, 3));
            endcase
            at = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
            if (i >= 150) step(u, 1'b1, 1'b0, BASE, 1'b0, 4'h0, 32'd0, 6'd0);
            else step(u, 1'b1, 1'($urandom), a, 1'($urandom), 4'($urandom), $urandom, at);
            checks++;
            if (obs_v !== exp_v) begin errors++; $display("FAIL random u=%0d cyc=%0d got=%h want=%h", u, cyc, obs_v, exp_v); end
         end
      end
   endtask

   initial begin
      for (int u = 0; u < 2; u++) begin
         rst_n[u] = 1'b0; req[u] = 1'b0; addr[u] = BASE; we[u] = 1'b0;
         be[u] = 4'h0; wdata[u] = 32'd0; atop[u] = 6'd0;
      end
      repeat (3) @(posedge clk);
      #1;
      cyc = 0;
      test_reset();
      test_fill();
      test_basic();
      test_byte_enable();
      test_errors();
      test_throttle();
      test_reset_mid();
      test_raw();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
